// File: rtl/peripheral_uart_rfifo_gen_wb.sv
// rtl/peripheral_uart_rfifo_gen_wb.sv - UART receive FIFO with per-entry status flags and trigger level
// First-word-fall-through storage with exact occupancy and flagged-entry counts.
module peripheral_uart_rfifo_gen_wb #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 3,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     wb_rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W+FLAG_W-1:0] data_in,
  input  logic                     fifo_reset,
  input  logic                     reset_status,
  input  logic [CNT_W-1:0]         thr,
  output logic [DATA_W+FLAG_W-1:0] data_out,
  output logic [CNT_W-1:0]         count,
  output logic                     empty,
  output logic                     full,
  output logic                     trigger,
  output logic                     overrun,
  output logic [CNT_W-1:0]         err_count,
  output logic                     error_bit
);

  localparam int W = DATA_W + FLAG_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [PTR_W-1:0] bottom_q, bottom_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             overrun_q, overrun_d;

  logic             push_ok, pop_ok, drop;
  logic             in_flagged, head_flagged;
  logic [CNT_W-1:0] thr_eff;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign err_count = err_count_q;
  assign error_bit = (err_count_q != '0);
  assign overrun   = overrun_q;
  assign data_out  = empty ? '0 : mem[bottom_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok       = pop & ~empty;
  assign push_ok      = push & (~full | pop_ok);
  assign drop         = push & ~push_ok;
  assign in_flagged   = |data_in[FLAG_W-1:0];
  assign head_flagged = |data_out[FLAG_W-1:0];

  always_comb begin
    thr_eff = thr;
    if (thr == '0) begin
      thr_eff = CNT_W'(1);
    end else if (thr > DEPTH_C) begin
      thr_eff = DEPTH_C;
    end
  end

  assign trigger = (count_q >= thr_eff);

  always_comb begin
    top_d       = top_q;
    bottom_d    = bottom_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    overrun_d   = overrun_q;
    if (push_ok) begin
      top_d = top_q + PTR_W'(1);
    end
    if (pop_ok) begin
      bottom_d = bottom_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    if ((push_ok && in_flagged) && !(pop_ok && head_flagged)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end else if (!(push_ok && in_flagged) && (pop_ok && head_flagged)) begin
      err_count_d = err_count_q - CNT_W'(1);
    end
    if (reset_status) begin
      overrun_d = 1'b0;
    end else if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i || fifo_reset) begin
      top_q       <= '0;
      bottom_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!wb_rst_i && !fifo_reset && push_ok) begin
      mem[top_q] <= data_in;
    end
  end

endmodule
